// File: rtl/fpu_sp_pkg.sv
// Shared definitions for the single-precision FPU command sequencer:
// opcodes, response flag bit positions and the sequencer state encoding.
package fpu_sp_pkg;

  localparam int OP_W   = 2;
  localparam int TAG_W  = 4;
  localparam int FLAG_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL = 2'b10;
  localparam logic [OP_W-1:0] OP_DIV = 2'b11;

  // rsp_flags = {timeout, underflow, overflow}
  localparam int FLAG_OVF = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_TMO = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fpu_sp_cmd_fifo.sv
// Command FIFO for the FPU sequencer: in-order storage of packed commands,
// synchronous active-low reset of pointers and occupancy.
module fpu_sp_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 70
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      // simultaneous push and pop leaves the occupancy unchanged
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_sp_sequencer.sv
// Queues FPU commands, issues them one at a time to an external FPU and
// returns tagged responses in order, with a bounded wait for fpu_ready.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no operation in flight; pop the FIFO head when available
// ST_ISSUE | operands presented to the FPU; fpu_ready still stale
// ST_WAIT  | waiting for fpu_ready, counting toward the timeout
// ST_RESP  | response held on rsp_* until rsp_ready
module fpu_sp_sequencer
  import fpu_sp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [WIDTH-1:0]  fpu_a,
  output logic [WIDTH-1:0]  fpu_b,
  output logic [OP_W-1:0]   fpu_opcode,
  input  logic [WIDTH-1:0]  fpu_result,
  input  logic              fpu_ready,
  input  logic              fpu_overflow,
  input  logic              fpu_underflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              busy
);

  localparam int CMD_W = 2 * WIDTH + OP_W + TAG_W;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_e state_q;
  seq_state_e state_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CMD_W-1:0]  fifo_wdata;
  logic [CMD_W-1:0]  fifo_rdata;

  logic [WIDTH-1:0]  head_a;
  logic [WIDTH-1:0]  head_b;
  logic [OP_W-1:0]   head_op;
  logic [TAG_W-1:0]  head_tag;

  logic [WIDTH-1:0]  fpu_a_q;
  logic [WIDTH-1:0]  fpu_b_q;
  logic [OP_W-1:0]   fpu_op_q;
  logic [TAG_W-1:0]  tag_q;
  logic [CNT_W-1:0]  wait_cnt_q;

  logic [WIDTH-1:0]  rsp_result_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic [FLAG_W-1:0] rsp_flags_q;

  logic [FLAG_W-1:0] cap_flags;
  logic [FLAG_W-1:0] tmo_flags;
  logic              wait_expired;

  // Nothing is accepted while reset is asserted.
  assign cmd_ready  = rst_n && !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_a, cmd_b, cmd_op, cmd_tag};
  assign {head_a, head_b, head_op, head_tag} = fifo_rdata;

  fpu_sp_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (CMD_W)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wait_expired = !fpu_ready && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    cap_flags           = '0;
    cap_flags[FLAG_OVF] = fpu_overflow;
    cap_flags[FLAG_UNF] = fpu_underflow;
    tmo_flags           = '0;
    tmo_flags[FLAG_TMO] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (fpu_ready || wait_expired) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_op_q     <= '0;
      tag_q        <= '0;
      wait_cnt_q   <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q <= state_d;
      // FPU operands only change on a pop, so they stay put through RESP.
      if (fifo_pop) begin
        fpu_a_q  <= head_a;
        fpu_b_q  <= head_b;
        fpu_op_q <= head_op;
        tag_q    <= head_tag;
      end
      case (state_q)
        ST_ISSUE: wait_cnt_q <= '0;
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          if (fpu_ready) begin
            rsp_result_q <= fpu_result;
            rsp_tag_q    <= tag_q;
            rsp_flags_q  <= cap_flags;
          end else if (wait_expired) begin
            rsp_result_q <= '0;
            rsp_tag_q    <= tag_q;
            rsp_flags_q  <= tmo_flags;
          end
        end
        default: wait_cnt_q <= wait_cnt_q;
      endcase
    end
  end

  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_opcode = fpu_op_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fpu_sp_sequencer.sv
// Bench for fpu_sp_sequencer: directed scenarios plus a randomized run
// scored against an in-order response queue and a behavioural FPU model.
module tb_fpu_sp_sequencer;
  import fpu_sp_pkg::*;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_tag = '0;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_opcode;
  logic [31:0] fpu_result;
  logic        fpu_ready;
  logic        fpu_overflow;
  logic        fpu_underflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic [2:0]  rsp_flags;
  logic        busy;

  logic        use_fn = 1'b0;
  logic [31:0] fix_result = '0;
  logic        fix_ready = 1'b0;
  logic        fix_ovf = 1'b0;
  logic        fix_unf = 1'b0;
  logic [31:0] fn_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_sp_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode),
    .fpu_result(fpu_result), .fpu_ready(fpu_ready),
    .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_flags(rsp_flags),
    .busy(busy)
  );

  // Stand-in FPU: an arbitrary but deterministic function of the operands.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      default: return a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  function automatic logic [38:0] exp_rsp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic [3:0] tag);
    logic [31:0] r;
    r = fpu_model(a, b, op);
    return {r, tag, 1'b0, r[30] & ~r[31], r[31]};
  endfunction

  assign fn_out        = fpu_model(fpu_a, fpu_b, fpu_opcode);
  assign fpu_result    = use_fn ? fn_out : fix_result;
  assign fpu_overflow  = use_fn ? fn_out[31] : fix_ovf;
  assign fpu_underflow = use_fn ? (fn_out[30] & ~fn_out[31]) : fix_unf;
  assign fpu_ready     = fix_ready;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [3:0] tag);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    #1;
    while (!cmd_ready && n < 60) begin
      @(negedge clk); #1; n++;
    end
    chk("push_accepted", 64'(n < 60), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!rsp_valid && n < 60);
  endtask

  task automatic get_rsp(output logic [38:0] got);
    int n;
    n = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    while (!rsp_valid && n < 60) begin
      @(negedge clk); #1; n++;
    end
    chk("rsp_arrives", 64'(n < 60), 64'(1));
    got = {rsp_result, rsp_tag, rsp_flags};
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    int low_run;
    int nrsp;
    logic [38:0] got;
    logic [38:0] expq[$];
    logic [31:0] ca[6];
    logic [31:0] cb[6];
    logic [1:0]  cop[6];

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_result", 64'(rsp_result), 64'(0));
    chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    chk("rst_rsp_flags", 64'(rsp_flags), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_fpu_ops", 64'({fpu_a, fpu_b, fpu_opcode}), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // single add, FPU already ready: response after three edges
    use_fn = 1'b0; fix_result = 32'h4040_0000; fix_ready = 1'b1;
    fix_ovf = 1'b0; fix_unf = 1'b0;
    push_cmd(32'h3F80_0000, 32'h4000_0000, OP_ADD, 4'd3);
    wait_valid(n);
    chk("add_latency", 64'(n), 64'(3));
    chk("add_fpu_a", 64'(fpu_a), 64'(32'h3F80_0000));
    chk("add_fpu_b", 64'(fpu_b), 64'(32'h4000_0000));
    chk("add_fpu_op", 64'(fpu_opcode), 64'(OP_ADD));
    get_rsp(got);
    chk("add_rsp", 64'(got), 64'({32'h4040_0000, 4'd3, 3'b000}));
    chk("add_valid_drop", 64'(rsp_valid), 64'(0));
    chk("add_busy_clear", 64'(busy), 64'(0));

    // overflow
    fix_result = 32'h7F80_0000; fix_ovf = 1'b1;
    push_cmd(32'h7F00_0000, 32'h7F00_0000, OP_MUL, 4'd9);
    wait_valid(n);
    chk("ovf_latency", 64'(n), 64'(3));
    get_rsp(got);
    chk("ovf_rsp", 64'(got), 64'({32'h7F80_0000, 4'd9, 3'b001}));
    chk("ovf_fpu_op", 64'(fpu_opcode), 64'(OP_MUL));

    // timeout: FPU never ready, garbage on the return path must be dropped
    fix_ready = 1'b0; fix_result = 32'hDEAD_BEEF; fix_ovf = 1'b1; fix_unf = 1'b1;
    push_cmd(32'h1234_5678, 32'h0BAD_F00D, OP_DIV, 4'd6);
    wait_valid(n);
    chk("tmo_latency", 64'(n), 64'(TIMEOUT + 2));
    get_rsp(got);
    chk("tmo_rsp", 64'(got), 64'({32'h0, 4'd6, 3'b100}));

    // fill, backpressure and in-order drain
    use_fn = 1'b1; fix_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ca[i] = $urandom; cb[i] = $urandom; cop[i] = 2'($urandom_range(0, 3));
    end
    push_cmd(ca[0], cb[0], cop[0], 4'd0);
    wait_valid(n);
    chk("fill_first_latency", 64'(n), 64'(3));
    for (int i = 1; i <= 4; i++) push_cmd(ca[i], cb[i], cop[i], 4'(i));
    chk("fill_full_ready", 64'(cmd_ready), 64'(0));
    chk("fill_busy", 64'(busy), 64'(1));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rsp", 64'({rsp_result, rsp_tag, rsp_flags}),
          64'(exp_rsp(ca[0], cb[0], cop[0], 4'd0)));
      chk("bp_fpu", 64'({fpu_a, fpu_b, fpu_opcode}), 64'({ca[0], cb[0], cop[0]}));
      chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_valid_drop", 64'(rsp_valid), 64'(0));
    chk("hs_still_full", 64'(cmd_ready), 64'(0));
    @(posedge clk); #1;
    chk("pop_frees_slot", 64'(cmd_ready), 64'(1));
    chk("pop_next_fpu", 64'({fpu_a, fpu_b, fpu_opcode}), 64'({ca[1], cb[1], cop[1]}));
    push_cmd(ca[5], cb[5], cop[5], 4'd5);
    for (int i = 1; i <= 5; i++) begin
      get_rsp(got);
      chk("fill_order", 64'(got), 64'(exp_rsp(ca[i], cb[i], cop[i], 4'(i))));
    end
    chk("fill_busy_clear", 64'(busy), 64'(0));

    // reset during WAIT with two commands queued
    use_fn = 1'b0; fix_ready = 1'b0;
    push_cmd(32'h1, 32'h2, OP_ADD, 4'd10);
    push_cmd(32'h3, 32'h4, OP_SUB, 4'd11);
    push_cmd(32'h5, 32'h6, OP_MUL, 4'd12);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("mid_rst_fpu", 64'({fpu_a, fpu_b, fpu_opcode}), 64'(0));
    fix_ready = 1'b1; rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    chk("mid_rst_no_rsp", 64'(seen), 64'(0));
    chk("mid_rst_idle", 64'(busy), 64'(0));

    // randomized traffic against the in-order reference queue
    use_fn = 1'b1;
    low_run = 0;
    nrsp = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_a = $urandom; cmd_b = $urandom;
      cmd_op = 2'($urandom_range(0, 3)); cmd_tag = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (low_run >= 5) fix_ready = 1'b1;
      else fix_ready = ($urandom_range(0, 1) == 1);
      low_run = fix_ready ? 0 : low_run + 1;
      #1;
      if (cmd_valid && cmd_ready) expq.push_back(exp_rsp(cmd_a, cmd_b, cmd_op, cmd_tag));
      if (rsp_valid && rsp_ready) begin
        chk("rnd_rsp_expected", 64'(expq.size() != 0), 64'(1));
        if (expq.size() != 0) begin
          chk("rnd_rsp", 64'({rsp_result, rsp_tag, rsp_flags}), 64'(expq.pop_front()));
          nrsp++;
        end
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1; fix_ready = 1'b1;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 200) begin
      @(negedge clk); #1;
      if (rsp_valid) begin
        chk("drain_rsp_expected", 64'(expq.size() != 0), 64'(1));
        if (expq.size() != 0) begin
          chk("drain_rsp", 64'({rsp_result, rsp_tag, rsp_flags}), 64'(expq.pop_front()));
          nrsp++;
        end
      end
      n++;
    end
    rsp_ready = 1'b0;
    chk("drain_empty", 64'(expq.size()), 64'(0));
    chk("drain_busy", 64'(busy), 64'(0));
    chk("rnd_traffic", 64'(nrsp > 50), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
